ext_bus_ctrl: RTL and testbench
===============================

EXT_BUS_CTRL -- requirements
Module: ext_bus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, request address width (multiple of BUS_W).
REQ-002 SHALL have parameter BUS_W, default 8, external bus width.
REQ-003 SHALL have parameter MAX_BYTES, default 4, maximum bus beats per request (power of two, >=2).
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, extra access cycles per beat (0..15).
REQ-005 SHALL have parameter ROM_TOP, default 16'h8000; addresses below it map to ROM, the rest to RAM.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 nrst  in  1  asynchronous active-low reset.
REQ-009 address  in  ADDR_W  start address of the request.
REQ-010 read / write  in  1 each  request strobes, sampled only in IDLE.
REQ-011 byte_count  in  log2(MAX_BYTES)  beats minus one (0 = 1 beat).
REQ-012 data_in  in  MAX_BYTES*BUS_W  write data, beat k in bits [BUS_W*k +: BUS_W].
REQ-013 data_out  out  MAX_BYTES*BUS_W  read data, same packing.
REQ-014 ready  out  1  one-cycle completion pulse; busy  out  1  high outside IDLE; err  out  1  qualified by ready.
REQ-015 bus_dout  out  BUS_W; bus_oe  out  1; bus_din  in  BUS_W  (tristate resolved outside).
REQ-016 latch  out  ADDR_W/BUS_W  address-latch strobes, bit i latches address byte i.
REQ-017 ram_ce, ram_rd, ram_wr, rom_ce, rom_rd  out  1 each, active high.

Function
REQ-018 States: IDLE, ASETUP, ALATCH, ACCESS, HOLD, DONE.
REQ-019 In IDLE, read or write high accepts the request: address, byte_count, data_in, direction and region are captured; read wins if both high.
REQ-020 Per beat k, the beat address is captured address + k, modulo 2^ADDR_W (wrap-around from all-ones to 0); region is decided per beat.
REQ-021 For each latch index i = 0..L-1 (L = ADDR_W/BUS_W): ASETUP one cycle drives beat-address byte i, bus_oe=1, latch=0; ALATCH one cycle keeps the same drive with latch[i]=1.
REQ-022 ACCESS lasts WAIT_CYCLES+1 cycles with the region's ce and rd (read) or ram_wr (write) high.
REQ-023 Write ACCESS drives data_in beat k with bus_oe=1; read ACCESS holds bus_oe=0 and samples bus_din into data_out beat k on the last ACCESS cycle.
REQ-024 HOLD one cycle: all ce/rd/wr/latch low, bus_oe=0; then next beat's ASETUP, or DONE after the last beat.
REQ-025 Beat length = 2L + WAIT_CYCLES + 2 cycles; defaults: 8 cycles; DONE begins 8*(byte_count+1) cycles after the accept edge.
REQ-026 DONE one cycle: ready=1, busy=0 next cycle in IDLE; a new request may be accepted on the edge leaving DONE's following IDLE cycle.
REQ-027 Read: data_out beats above byte_count cleared to 0 at accept; data_out stable from DONE until the next accepted read.
REQ-028 Write to a ROM-region beat: no rom_ce/ram_wr strobe for that beat (timing unchanged), err=1 with ready; other beats proceed normally.
REQ-029 read/write changes while busy are ignored; no queueing.
REQ-030 At most one of ram_ce, rom_ce is high; rd and wr never both high; latch never high in the same cycle as any ce.

Reset
REQ-031 nrst low asynchronously forces IDLE, all strobes, bus_oe, ready, busy, err to 0 and bus_dout, data_out to 0, including mid-transaction.
REQ-032 After nrst rises, the first rising edge with read/write high is accepted normally.

Verification
REQ-033 Read, address 16'h9000, byte_count 0, bus_din=8'hA5 -> latch[0] cycle 1, latch[1] cycle 3, ram_ce+ram_rd cycles 4-6, ready cycle 8, data_out=32'h000000A5, err=0.
REQ-034 Write 16'h9001, byte_count 3, data_in 32'h44332211 -> bus_dout 11,22,33,44 at addresses 9001..9004 with ram_wr, ready at cycle 32.
REQ-035 Read 16'hFFFF, byte_count 1 -> beat 0 RAM at FFFF, beat 1 ROM at 0000 (rom_ce+rom_rd), wrap verified.
REQ-036 Write 16'h7FFF, byte_count 1 -> no strobe beat 0, ram_wr at 8000 beat 1, ready with err=1.
REQ-037 read and write both high at accept -> read performed, no ram_wr ever; ignore request toggles while busy.
REQ-038 nrst low during ACCESS of beat 2 -> all outputs 0 immediately; after release, new 1-beat read completes in 8 cycles.

Source files
------------

// File: rtl/ext_bus_ctrl.sv
// External multiplexed-address bus controller: latches the beat address byte by byte,
// then runs a wait-stated ROM/RAM access per beat, for requests of up to MAX_BYTES beats.
module ext_bus_ctrl #(
  parameter int                ADDR_W      = 16,
  parameter int                BUS_W       = 8,
  parameter int                MAX_BYTES   = 4,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] ROM_TOP     = 16'h8000,
  localparam int               L           = ADDR_W / BUS_W,
  localparam int               CNT_W       = $clog2(MAX_BYTES),
  localparam int               LIDX_W      = (L > 1) ? $clog2(L) : 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [ADDR_W-1:0]          address,
  input  logic                       read,
  input  logic                       write,
  input  logic [CNT_W-1:0]           byte_count,
  input  logic [MAX_BYTES*BUS_W-1:0] data_in,
  output logic [MAX_BYTES*BUS_W-1:0] data_out,
  output logic                       ready,
  output logic                       busy,
  output logic                       err,
  output logic [BUS_W-1:0]           bus_dout,
  output logic                       bus_oe,
  input  logic [BUS_W-1:0]           bus_din,
  output logic [L-1:0]               latch,
  output logic                       ram_ce,
  output logic                       ram_rd,
  output logic                       ram_wr,
  output logic                       rom_ce,
  output logic                       rom_rd,
  output logic [2:0]                 o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ASETUP = 3'd1,
    S_ALATCH = 3'd2,
    S_ACCESS = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [ADDR_W-1:0]          r_addr;
  logic [CNT_W-1:0]           r_cnt;
  logic [CNT_W-1:0]           r_beat;
  logic [LIDX_W-1:0]          r_lidx;
  logic [3:0]                 r_wait;
  logic [MAX_BYTES*BUS_W-1:0] r_wdata;
  logic [MAX_BYTES*BUS_W-1:0] r_rdata;
  logic                       r_is_rd;
  logic                       r_err;

  logic [ADDR_W-1:0]          w_baddr;
  logic                       w_rom;
  logic                       w_accept;
  logic                       w_lat_last;
  logic                       w_wait_last;
  logic                       w_beat_last;
  logic [BUS_W-1:0]           w_abyte;
  logic [BUS_W-1:0]           w_wbyte;
  logic [L-1:0]               w_lat_sel;

  // Beat address wraps naturally at 2^ADDR_W; region is decided per beat.
  assign w_baddr     = r_addr + ADDR_W'(r_beat);
  assign w_rom       = (w_baddr < ROM_TOP);
  assign w_accept    = (r_state == S_IDLE) && (read || write);
  assign w_lat_last  = (r_lidx == LIDX_W'(L - 1));
  assign w_wait_last = (r_wait == 4'(WAIT_CYCLES));
  assign w_beat_last = (r_beat == r_cnt);

  assign busy        = (r_state != S_IDLE);
  assign data_out    = r_rdata;
  assign o_dbg_state = r_state;

  always_comb begin
    w_abyte   = '0;
    w_lat_sel = '0;
    w_wbyte   = '0;
    for (int i = 0; i < L; i++) begin
      if (r_lidx == LIDX_W'(i)) begin
        w_abyte      = w_baddr[i*BUS_W +: BUS_W];
        w_lat_sel[i] = 1'b1;
      end
    end
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (r_beat == CNT_W'(k)) w_wbyte = r_wdata[k*BUS_W +: BUS_W];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (read || write) w_next = S_ASETUP;
      S_ASETUP: w_next = S_ALATCH;
      S_ALATCH: w_next = w_lat_last ? S_ACCESS : S_ASETUP;
      S_ACCESS: if (w_wait_last) w_next = S_HOLD;
      S_HOLD:   w_next = w_beat_last ? S_DONE : S_ASETUP;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset clears them at once.
  always_comb begin
    latch    = '0;
    bus_oe   = 1'b0;
    bus_dout = '0;
    ram_ce   = 1'b0;
    ram_rd   = 1'b0;
    ram_wr   = 1'b0;
    rom_ce   = 1'b0;
    rom_rd   = 1'b0;
    ready    = 1'b0;
    err      = 1'b0;
    case (r_state)
      S_ASETUP: begin
        bus_oe   = 1'b1;
        bus_dout = w_abyte;
      end
      S_ALATCH: begin
        bus_oe   = 1'b1;
        bus_dout = w_abyte;
        latch    = w_lat_sel;
      end
      S_ACCESS: begin
        if (r_is_rd) begin
          ram_ce = !w_rom;
          ram_rd = !w_rom;
          rom_ce = w_rom;
          rom_rd = w_rom;
        end else begin
          // A write into ROM space keeps its timing but enables no device.
          bus_oe   = 1'b1;
          bus_dout = w_wbyte;
          ram_ce   = !w_rom;
          ram_wr   = !w_rom;
        end
      end
      S_DONE: begin
        ready = 1'b1;
        err   = r_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_lidx  <= '0;
      r_wait  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_is_rd <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= address;
        r_cnt   <= byte_count;
        r_wdata <= data_in;
        r_is_rd <= read;
        r_err   <= 1'b0;
        r_beat  <= '0;
        r_lidx  <= '0;
        r_wait  <= '0;
        if (read) begin
          for (int k = 0; k < MAX_BYTES; k++) begin
            if (CNT_W'(k) > byte_count) r_rdata[k*BUS_W +: BUS_W] <= '0;
          end
        end
      end
      if (r_state == S_ALATCH) r_lidx <= w_lat_last ? '0 : r_lidx + 1'b1;
      if (r_state == S_ACCESS) begin
        r_wait <= w_wait_last ? 4'd0 : r_wait + 4'd1;
        if (!r_is_rd && w_rom) r_err <= 1'b1;
        if (r_is_rd && w_wait_last) begin
          for (int k = 0; k < MAX_BYTES; k++) begin
            if (r_beat == CNT_W'(k)) r_rdata[k*BUS_W +: BUS_W] <= bus_din;
          end
        end
      end
      if (r_state == S_HOLD) r_beat <= r_beat + 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Bench for ext_bus_ctrl: a latch-and-memory model on the external bus feeds a scoreboard
// of expected bus accesses; completion latency, err and data_out are checked per request.
module tb_ext_bus_ctrl;

  localparam logic [15:0] ROM_TOP = 16'h8000;
  localparam logic [4:0]  K_RAM_RD = 5'b11000;  // {ram_ce, ram_rd, ram_wr, rom_ce, rom_rd}
  localparam logic [4:0]  K_RAM_WR = 5'b10100;
  localparam logic [4:0]  K_ROM_RD = 5'b00011;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  byte_count = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        ready, busy, err;
  logic [7:0]  bus_dout, bus_din;
  logic        bus_oe;
  logic [1:0]  latch;
  logic        ram_ce, ram_rd, ram_wr, rom_ce, rom_rd;
  logic [2:0]  dbg_state;

  ext_bus_ctrl dut (
    .clk(clk), .nrst(nrst), .address(address), .read(read), .write(write),
    .byte_count(byte_count), .data_in(data_in), .data_out(data_out),
    .ready(ready), .busy(busy), .err(err), .bus_dout(bus_dout), .bus_oe(bus_oe),
    .bus_din(bus_din), .latch(latch), .ram_ce(ram_ce), .ram_rd(ram_rd),
    .ram_wr(ram_wr), .rom_ce(rom_ce), .rom_rd(rom_rd), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_dout = '0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          first_l0, first_l1, first_ce;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h35;
  endfunction

  // ---------------- external bus model + monitor ----------------
  logic [7:0]  lat_lo = '0, lat_hi = '0;
  logic        prev_ce = 1'b0;
  logic [31:0] obs;

  assign bus_din = mem_f({lat_hi, lat_lo});

  always @(negedge clk) begin
    if (latch[0]) lat_lo = bus_dout;
    if (latch[1]) lat_hi = bus_dout;
    if ((ram_ce || rom_ce) && !prev_ce) begin
      obs = {2'b00, bus_oe, ram_ce, ram_rd, ram_wr, rom_ce, rom_rd, lat_hi, lat_lo,
             bus_oe ? bus_dout : 8'h00};
      if (exp_q.size() == 0) check("unexpected_evt", obs, 0);
      else                   check("bus_evt", obs, exp_q.pop_front());
    end
    prev_ce = ram_ce || rom_ce;
    if (busy)
      check("strobe_excl", (ram_ce && rom_ce) || ((ram_rd || rom_rd) && ram_wr) ||
                           ((|latch) && (ram_ce || rom_ce)), 0);
  end

  // ---------------- driver ----------------
  task automatic push_expect(input logic rd, input logic [15:0] addr, input logic [1:0] bc,
                             input logic [31:0] din, output logic exp_err, output int n_strobe);
    logic [15:0] a;
    exp_err  = 1'b0;
    n_strobe = 0;
    if (rd) for (int k = 0; k < 4; k++) if (k > bc) exp_dout[k*8 +: 8] = 8'h00;
    for (int k = 0; k <= bc; k++) begin
      a = addr + 16'(k);
      if (rd) begin
        exp_dout[k*8 +: 8] = mem_f(a);
        exp_q.push_back({2'b00, 1'b0, (a < ROM_TOP) ? K_ROM_RD : K_RAM_RD, a, 8'h00});
        n_strobe++;
      end else if (a < ROM_TOP) begin
        exp_err = 1'b1;
      end else begin
        exp_q.push_back({2'b00, 1'b1, K_RAM_WR, a, din[k*8 +: 8]});
        n_strobe++;
      end
    end
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [1:0] bc, input logic [31:0] din, input bit noise);
    logic exp_err;
    int   n_strobe, n, n_ce;
    @(negedge clk);
    address = addr; byte_count = bc; data_in = din; read = rd; write = wr;
    push_expect(rd, addr, bc, din, exp_err, n_strobe);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    first_l0 = -1; first_l1 = -1; first_ce = -1;
    n = 0; n_ce = 0;
    while (n < 200) begin
      @(negedge clk);
      if (latch[0] && first_l0 < 0) first_l0 = n;
      if (latch[1] && first_l1 < 0) first_l1 = n;
      if (ram_ce || rom_ce) begin
        n_ce++;
        if (first_ce < 0) first_ce = n;
      end
      if (ready) break;
      if (noise) begin
        read  = 1'($urandom_range(0, 1));
        write = 1'($urandom_range(0, 1));
      end
      n++;
    end
    read = 1'b0; write = 1'b0;
    check("done_latency", n, 8 * (bc + 1));
    check("err", err, exp_err);
    check("data_out", data_out, exp_dout);
    check("ce_cycles", n_ce, 3 * n_strobe);
    check("sb_empty", exp_q.size(), 0);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_state", dbg_state, 3'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ra;
    logic        rrd, rwr, dummy_err;
    int          dummy_n;

    #1;
    check("rst_busy", busy, 0);
    check("rst_strobes", {ram_ce, ram_rd, ram_wr, rom_ce, rom_rd, bus_oe, latch}, 0);
    check("rst_data_out", data_out, 0);
    check("rst_state", dbg_state, 3'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;

    // Single-beat RAM read with exact cycle positions.
    do_req(1'b1, 1'b0, 16'h9000, 2'd0, 32'h0, 1'b0);
    check("r33_lat0_cyc", first_l0, 1);
    check("r33_lat1_cyc", first_l1, 3);
    check("r33_ce_cyc", first_ce, 4);
    check("r33_data", data_out, 32'h000000A5);

    // Four-beat RAM write.
    do_req(1'b0, 1'b1, 16'h9001, 2'd3, 32'h44332211, 1'b0);
    check("r34_keep_dout", data_out, 32'h000000A5);

    // Read wrapping from FFFF (RAM) to 0000 (ROM).
    do_req(1'b1, 1'b0, 16'hFFFF, 2'd1, 32'h0, 1'b0);
    check("r35_data", data_out, {16'h0, mem_f(16'h0000), mem_f(16'hFFFF)});

    // Write straddling the ROM/RAM boundary.
    do_req(1'b0, 1'b1, 16'h7FFF, 2'd1, 32'hDEADBEEF, 1'b0);

    // Both strobes at accept, request toggling while busy.
    do_req(1'b1, 1'b1, 16'h9100, 2'd3, 32'hCAFEF00D, 1'b1);
    do_req(1'b1, 1'b0, 16'hC000, 2'd0, 32'h0, 1'b1);

    // Random requests biased toward the region boundary and wrap point.
    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 2))
        0:       ra = 16'($urandom);
        1:       ra = 16'h7FFD + 16'($urandom_range(0, 4));
        default: ra = 16'hFFFD + 16'($urandom_range(0, 4));
      endcase
      rrd = 1'($urandom_range(0, 1));
      rwr = rrd ? 1'($urandom_range(0, 1)) : 1'b1;
      do_req(rrd, rwr, ra, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset during the ACCESS of beat 2.
    @(negedge clk);
    address = 16'hA000; byte_count = 2'd3; read = 1'b1; write = 1'b0;
    push_expect(1'b1, 16'hA000, 2'd3, 32'h0, dummy_err, dummy_n);
    @(posedge clk); #1;
    read = 1'b0;
    for (int n = 0; n < 22; n++) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_strobes", {ram_ce, ram_rd, ram_wr, rom_ce, rom_rd, bus_oe, latch, ready, err}, 0);
    check("mid_rst_bus_dout", bus_dout, 0);
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_state", dbg_state, 3'd0);
    check("mid_rst_q_left", exp_q.size(), 1);
    exp_q.delete();
    exp_dout = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    do_req(1'b1, 1'b0, 16'h9234, 2'd0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
